// File: rtl/lane_detector_pkg.sv
// Shared widths, types and helpers for the lane detector.
package lane_detector_pkg;

    localparam int NUM_LANES = 5;
    localparam int CNT_W     = 8;
    localparam int COORD_W   = 11;

    typedef logic [NUM_LANES-1:0] lanes_t;
    typedef logic [CNT_W-1:0]     count_t;
    typedef logic [COORD_W-1:0]   coord_t;

    localparam count_t CNT_MAX   = '1;
    localparam coord_t COORD_MAX = '1;

    // First column of lane window idx.
    function automatic int lane_start(input int lane0_x, input int pitch, input int idx);
        return lane0_x + idx * pitch;
    endfunction

endpackage

// File: rtl/lane_counter.sv
// One lane window: column compare, 8-bit saturating pixel counter with
// clear, and the note threshold compare.
module lane_counter
    import lane_detector_pkg::*;
#(
    parameter int WIN_START = 400,
    parameter int WIN_WIDTH = 32,
    parameter int MIN_COUNT = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [10:0] x,
    input  logic        pix_en,
    input  logic        clr,
    output logic        hit
);

    localparam coord_t WIN_LO = coord_t'(WIN_START);
    localparam coord_t WIN_HI = coord_t'(WIN_START + WIN_WIDTH - 1);
    localparam count_t THRESH = count_t'(MIN_COUNT);

    logic   in_win;
    count_t count_d;
    count_t count_q;

    // Current column falls inside this lane's window.
    always_comb begin
        in_win = (x >= WIN_LO) && (x <= WIN_HI);
    end

    // Clear has priority; otherwise count qualified pixels, holding at full scale.
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (pix_en && in_win && (count_q != CNT_MAX)) begin
            count_d = count_q + count_t'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // A note is present once enough edge pixels landed in the window.
    always_comb begin
        hit = (count_q >= THRESH);
    end

endmodule

// File: rtl/lane_detector.sv
// Lane detector: tracks column/row of the incoming edge stream, counts set
// pixels in five lane windows on one scan row, and publishes a per-frame
// 5-bit result through a valid/ack handshake with a sticky overrun flag.
module lane_detector
    import lane_detector_pkg::*;
#(
    parameter int H_ACTIVE   = 1280,
    parameter int SCAN_ROW   = 600,
    parameter int LANE0_X    = 400,
    parameter int LANE_PITCH = 96,
    parameter int LANE_WIDTH = 32,
    parameter int MIN_COUNT  = 8
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        VSync,
    input  logic        HSync,
    input  logic        VDE,
    input  logic        ProcessIn,
    input  logic        Enable,
    input  logic        LanesAck,
    output logic [4:0]  Lanes,
    output logic        LanesValid,
    output logic        Overrun,
    output logic [10:0] RowCount
);

    localparam coord_t X_MAX  = coord_t'(H_ACTIVE - 1);
    localparam coord_t SCAN_Y = coord_t'(SCAN_ROW);

    logic   vde_q;
    logic   vsync_q;
    coord_t x_d;
    coord_t x_q;
    coord_t y_d;
    coord_t y_q;
    lanes_t lanes_d;
    lanes_t lanes_q;
    logic   valid_d;
    logic   valid_q;
    logic   overrun_d;
    logic   overrun_q;

    logic   vde_fall;
    logic   vsync_rise;
    logic   on_scan_row;
    logic   pix_en;
    logic   commit;
    logic   cnt_clr;
    lanes_t lane_hit;

    // HSync travels with the video bundle but line boundaries are taken from VDE.
    logic unused_hsync;
    assign unused_hsync = HSync;

    // Edge detects and per-cycle qualifiers; the row value seen here is the
    // pre-increment one, so the commit on a VDE fall belongs to the row just ended.
    always_comb begin
        vde_fall    = vde_q & ~VDE;
        vsync_rise  = VSync & ~vsync_q;
        on_scan_row = (y_q == SCAN_Y);
        pix_en      = Enable & on_scan_row & VDE & ProcessIn;
        commit      = Enable & on_scan_row & vde_fall;
        cnt_clr     = ~Enable | commit;
    end

    // Column counter: holds the index of the pixel currently on the input.
    always_comb begin
        x_d = x_q;
        if (vde_fall) begin
            x_d = '0;
        end else if (VDE && (x_q != X_MAX)) begin
            x_d = x_q + coord_t'(1);
        end
    end

    // Row counter: a VSync rise wins over a coincident end of line.
    always_comb begin
        y_d = y_q;
        if (vsync_rise) begin
            y_d = '0;
        end else if (vde_fall && (y_q != COORD_MAX)) begin
            y_d = y_q + coord_t'(1);
        end
    end

    // Result register and handshake: a commit always loads; an ack on the same
    // cycle counts as consuming the old result, so no overrun is flagged.
    always_comb begin
        lanes_d   = lanes_q;
        valid_d   = valid_q;
        overrun_d = overrun_q;
        if (commit) begin
            lanes_d = lane_hit;
            valid_d = 1'b1;
            if (LanesAck) begin
                overrun_d = 1'b0;
            end else if (valid_q) begin
                overrun_d = 1'b1;
            end
        end else if (LanesAck && valid_q) begin
            valid_d   = 1'b0;
            overrun_d = 1'b0;
        end
    end

    // Per-lane window counters.
    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        lane_counter #(
            .WIN_START (lane_start(LANE0_X, LANE_PITCH, i)),
            .WIN_WIDTH (LANE_WIDTH),
            .MIN_COUNT (MIN_COUNT)
        ) u_lane_counter (
            .clk    (CLK),
            .rst    (RST),
            .x      (x_q),
            .pix_en (pix_en),
            .clr    (cnt_clr),
            .hit    (lane_hit[i])
        );
    end

    // State registers.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            vde_q     <= 1'b0;
            vsync_q   <= 1'b0;
            x_q       <= '0;
            y_q       <= '0;
            lanes_q   <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            vde_q     <= VDE;
            vsync_q   <= VSync;
            x_q       <= x_d;
            y_q       <= y_d;
            lanes_q   <= lanes_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
        end
    end

    // Outputs straight from registers.
    always_comb begin
        Lanes      = lanes_q;
        LanesValid = valid_q;
        Overrun    = overrun_q;
        RowCount   = y_q;
    end

endmodule

// File: tb/tb_lane_detector.sv
// Directed bench for lane_detector: short blank-ish lines up to the scan row,
// one full-width scan row per frame, hand-computed lane results.
module tb_lane_detector;

    logic        CLK = 1'b0;
    logic        RST;
    logic        VSync;
    logic        HSync;
    logic        VDE;
    logic        ProcessIn;
    logic        Enable;
    logic        LanesAck;
    logic [4:0]  Lanes;
    logic        LanesValid;
    logic        Overrun;
    logic [10:0] RowCount;

    int n_checks = 0;
    int n_pass   = 0;
    logic [1279:0] row_pix;

    lane_detector dut (
        .CLK        (CLK),
        .RST        (RST),
        .VSync      (VSync),
        .HSync      (HSync),
        .VDE        (VDE),
        .ProcessIn  (ProcessIn),
        .Enable     (Enable),
        .LanesAck   (LanesAck),
        .Lanes      (Lanes),
        .LanesValid (LanesValid),
        .Overrun    (Overrun),
        .RowCount   (RowCount)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic chk_out(input string tag, input logic [4:0] lanes, input logic valid, input logic ovr);
        chk({tag, "_lanes"},   32'(Lanes),      32'(lanes));
        chk({tag, "_valid"},   32'(LanesValid), 32'(valid));
        chk({tag, "_overrun"}, 32'(Overrun),    32'(ovr));
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_pix(input int lo, input int hi);
        for (int c = lo; c <= hi; c++) row_pix[11'(c)] = 1'b1;
    endtask

    task automatic vsync_pulse();
        VSync = 1'b1;
        tick();
        tick();
        VSync = 1'b0;
        tick();
    endtask

    task automatic short_line();
        VDE = 1'b1;
        tick();
        VDE = 1'b0;
        HSync = 1'b1;
        tick();
        HSync = 1'b0;
    endtask

    task automatic ack_pulse();
        LanesAck = 1'b1;
        tick();
        LanesAck = 1'b0;
    endtask

    // Full-width line from row_pix. Enable is low on columns drop_lo..drop_hi,
    // and also on the end-of-line cycle when drop_hi reaches past the line.
    task automatic scan_line(input int drop_lo, input int drop_hi, input logic ack_commit, input int rst_at);
        for (int c = 0; c < 1280; c++) begin
            VDE       = 1'b1;
            ProcessIn = row_pix[11'(c)];
            Enable    = !(c >= drop_lo && c <= drop_hi);
            if (c == rst_at) begin
                RST = 1'b1;
                #1;
                chk_out("rst_mid", 5'h00, 1'b0, 1'b0);
                chk("rst_mid_row", 32'(RowCount), 32'd0);
                #1 RST = 1'b0;
            end
            tick();
        end
        VDE       = 1'b0;
        ProcessIn = 1'b0;
        Enable    = !(drop_hi >= 1280);
        LanesAck  = ack_commit;
        HSync     = 1'b1;
        tick();
        LanesAck  = 1'b0;
        Enable    = 1'b1;
        HSync     = 1'b0;
    endtask

    task automatic run_frame(input int drop_lo, input int drop_hi, input logic ack_commit, input int rst_at);
        vsync_pulse();
        repeat (600) short_line();
        scan_line(drop_lo, drop_hi, ack_commit, rst_at);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        RST = 1'b1; VSync = 1'b0; HSync = 1'b0; VDE = 1'b0; ProcessIn = 1'b0;
        Enable = 1'b1; LanesAck = 1'b0; row_pix = '0;
        tick();
        tick();
        chk_out("reset", 5'h00, 1'b0, 1'b0);
        chk("reset_row", 32'(RowCount), 32'd0);
        RST = 1'b0;
        tick();

        // Lane 0 full, lane 2 nine pixels.
        row_pix = '0; set_pix(400, 431); set_pix(592, 600);
        run_frame(-1, -2, 1'b0, -1);
        chk_out("basic", 5'h05, 1'b1, 1'b0);
        chk("basic_row", 32'(RowCount), 32'd601);
        ack_pulse();
        chk_out("basic_ack", 5'h05, 1'b0, 1'b0);

        // Seven pixels in lane 4; columns just outside lane 0.
        row_pix = '0; set_pix(784, 790); set_pix(399, 399); set_pix(432, 432);
        run_frame(-1, -2, 1'b0, -1);
        chk_out("seven", 5'h00, 1'b1, 1'b0);
        ack_pulse();

        // Eight pixels in lane 4.
        row_pix = '0; set_pix(784, 791); set_pix(399, 399); set_pix(432, 432);
        run_frame(-1, -2, 1'b0, -1);
        chk_out("eight", 5'h10, 1'b1, 1'b0);

        // Second frame without ack: overwrite plus overrun.
        row_pix = '0; set_pix(496, 527);
        run_frame(-1, -2, 1'b0, -1);
        chk_out("overrun", 5'h02, 1'b1, 1'b1);
        ack_pulse();
        chk_out("overrun_ack", 5'h02, 1'b0, 1'b0);

        // Ack on the commit cycle of frame 2.
        row_pix = '0; set_pix(688, 695);
        run_frame(-1, -2, 1'b0, -1);
        chk_out("f1", 5'h08, 1'b1, 1'b0);
        row_pix = '0; set_pix(400, 407); set_pix(784, 791);
        run_frame(-1, -2, 1'b1, -1);
        chk_out("ack_commit", 5'h11, 1'b1, 1'b0);
        ack_pulse();
        chk_out("ack_commit_ack", 5'h11, 1'b0, 1'b0);

        // Enable low for the whole scan row: no commit.
        row_pix = '0; set_pix(592, 623);
        run_frame(0, 2000, 1'b0, -1);
        chk_out("disabled", 5'h11, 1'b0, 1'b0);

        // Enable drops mid-row and stays low; the next frame starts from zero.
        row_pix = '0; set_pix(400, 431);
        run_frame(440, 2000, 1'b0, -1);
        chk_out("drop_hold", 5'h11, 1'b0, 1'b0);
        row_pix = '0; set_pix(400, 403);
        run_frame(-1, -2, 1'b0, -1);
        chk_out("after_drop", 5'h00, 1'b1, 1'b0);
        ack_pulse();

        // Enable blips low mid-row: lane 0 pixels before the blip are lost.
        row_pix = '0; set_pix(400, 431); set_pix(784, 791);
        run_frame(500, 509, 1'b0, -1);
        chk_out("drop_blip", 5'h10, 1'b1, 1'b0);

        // Reset in the middle of the scan row, then a clean frame.
        row_pix = '0; set_pix(592, 623);
        run_frame(-1, -2, 1'b0, 610);
        chk_out("post_rst", 5'h00, 1'b0, 1'b0);
        chk("post_rst_row", 32'(RowCount), 32'd1);
        row_pix = '0; set_pix(688, 719);
        run_frame(-1, -2, 1'b0, -1);
        chk_out("recover", 5'h08, 1'b1, 1'b0);
        ack_pulse();

        // Missing VSync: row counter runs past the scan row, no commit, saturates.
        row_pix = '0; set_pix(400, 431);
        repeat (600) short_line();
        scan_line(-1, -2, 1'b0, -1);
        chk_out("no_vsync", 5'h08, 1'b0, 1'b0);
        chk("no_vsync_row", 32'(RowCount), 32'd1202);
        repeat (900) short_line();
        chk("row_sat", 32'(RowCount), 32'd2047);

        // VSync rise coincident with end of line: clear wins.
        VDE = 1'b1;
        tick();
        VDE = 1'b0;
        VSync = 1'b1;
        tick();
        chk("vsync_vs_fall", 32'(RowCount), 32'd0);
        VSync = 1'b0;
        tick();
        row_pix = '0; set_pix(496, 527);
        repeat (600) short_line();
        scan_line(-1, -2, 1'b0, -1);
        chk_out("resync", 5'h02, 1'b1, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
